pos_manager_n: RTL and testbench

- N-channel wheel-encoder position manager; parametrised successor to the two-motor position block in the MotorSpeedPosition IP.
- Per channel: counts rising edges of a sensor input into a free-running absolute counter and a rebasing relative counter.
- Provides pairwise differences against channel 0, a free-running clock counter and an atomic snapshot for the AXI/software side.
- Sits between the motor encoder pins and the speed/position register file.

---
 rtl/pos_pkg.sv | 9 +
 rtl/pos_channel.sv | 63 ++++++
 rtl/pos_manager_n.sv | 88 ++++++++
 tb/tb_pos_manager_n.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pos_pkg.sv
// Shared constants for the wheel-encoder position manager: clear-bit indices
// and default widths.
package pos_pkg;
  localparam int CLR_REL    = 0;
  localparam int CLR_ABS    = 1;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_POS_W  = 16;
  localparam int DEF_TS_W   = 32;
endpackage

// File: rtl/pos_channel.sv
// One encoder channel: rising-edge detect, absolute and saturating relative counters.
// POS_INPUT_SYNC_EN adds a 2-flop input synchroniser ahead of the edge detector.
module pos_channel import pos_pkg::*; #(
  parameter int POS_W = DEF_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_i,
  input  logic             clr_rel_i,
  input  logic             clr_abs_i,
  input  logic             rebase_en_i,
  input  logic [POS_W-1:0] min_rel_i,
  output logic [POS_W-1:0] abs_o,
  output logic [POS_W-1:0] rel_o,
  output logic             ovf_o
);
  logic             sens_w, sensor_q, edge_w;
  logic [POS_W-1:0] abs_q, abs_d, rel_q, rel_d, rel_sub;
  logic [POS_W:0]   rel_sum;
  logic             ovf_q, ovf_d;

`ifdef POS_INPUT_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], sensor_i};
  assign sens_w = sync_q[1];
`else
  assign sens_w = sensor_i;
`endif

  assign edge_w  = sens_w & ~sensor_q;
  // rel is never below the shared minimum, so the subtraction cannot borrow
  assign rel_sub = rel_q - (rebase_en_i ? min_rel_i : '0);
  assign rel_sum = {1'b0, rel_sub} + {{POS_W{1'b0}}, edge_w};

  always_comb begin
    abs_d = clr_abs_i ? '0 : abs_q + {{(POS_W-1){1'b0}}, edge_w};
    rel_d = rel_sum[POS_W] ? '1 : rel_sum[POS_W-1:0];
    ovf_d = ovf_q | rel_sum[POS_W];
    if (clr_rel_i) begin
      rel_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sensor_q <= 1'b0;
      abs_q    <= '0;
      rel_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sensor_q <= sens_w;
      abs_q    <= abs_d;
      rel_q    <= rel_d;
      ovf_q    <= ovf_d;
    end

  assign abs_o = abs_q;
  assign rel_o = rel_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/pos_manager_n.sv
// N-channel encoder position manager: per-channel counters, shared rebase,
// differences against channel 0, cycle counter and atomic snapshot.
module pos_manager_n import pos_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int POS_W  = DEF_POS_W,
  parameter int TS_W   = DEF_TS_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          sensor,
  input  logic [1:0]                 clear,
  input  logic                       snap,
  output logic [NUM_CH*POS_W-1:0]    pos_abs,
  output logic [NUM_CH*POS_W-1:0]    pos_rel,
  output logic [(NUM_CH-1)*POS_W-1:0] pos_diff,
  output logic [TS_W-1:0]            count_clk,
  output logic                       rebase,
  output logic [NUM_CH-1:0]          ovf,
  output logic                       snap_valid,
  output logic [TS_W-1:0]            snap_ts,
  output logic [NUM_CH*POS_W-1:0]    snap_rel
);
  logic [NUM_CH-1:0][POS_W-1:0] abs_w, rel_w, snap_rel_q;
  logic [POS_W-1:0]             min_w;
  logic                         r_w;
  logic [TS_W-1:0]              cnt_q, cnt_d, snap_ts_q;
  logic                         rebase_q, rebase_d, snap_vld_q;

  // Rebase when any relative counter reaches its top half
  always_comb begin
    min_w = rel_w[0];
    r_w   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rel_w[i] < min_w) min_w = rel_w[i];
      r_w = r_w | rel_w[i][POS_W-1];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pos_channel #(.POS_W(POS_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sensor_i   (sensor[g]),
      .clr_rel_i  (clear[CLR_REL]),
      .clr_abs_i  (clear[CLR_ABS]),
      .rebase_en_i(r_w),
      .min_rel_i  (min_w),
      .abs_o      (abs_w[g]),
      .rel_o      (rel_w[g]),
      .ovf_o      (ovf[g])
    );
  end

  for (genvar g = 1; g < NUM_CH; g++) begin : g_diff
    assign pos_diff[(g-1)*POS_W +: POS_W] = rel_w[g] - rel_w[0];
  end

  always_comb begin
    cnt_d    = clear[CLR_REL] ? '0 : cnt_q + 1'b1;
    rebase_d = r_w & ~clear[CLR_REL];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q      <= '0;
      rebase_q   <= 1'b0;
      snap_vld_q <= 1'b0;
      snap_ts_q  <= '0;
      snap_rel_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rebase_q   <= rebase_d;
      snap_vld_q <= snap;
      // capture pre-update values so a coincident clear/rebase is not seen
      if (snap) begin
        snap_ts_q  <= cnt_q;
        snap_rel_q <= rel_w;
      end
    end

  assign pos_abs    = abs_w;
  assign pos_rel    = rel_w;
  assign count_clk  = cnt_q;
  assign rebase     = rebase_q;
  assign snap_valid = snap_vld_q;
  assign snap_ts    = snap_ts_q;
  assign snap_rel   = snap_rel_q;
endmodule

// File: tb/tb_pos_manager_n.sv
// Directed bench for pos_manager_n, built with narrow POS_W so counter
// wrap/rebase/saturation points are reached in a few hundred cycles.
module tb_pos_manager_n;
  localparam int NCH = 2;
  localparam int PW  = 8;
  localparam int TW  = 32;
`ifdef POS_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NCH-1:0]          sensor;
  logic [1:0]              clear;
  logic                    snap;
  logic [NCH*PW-1:0]       pos_abs, pos_rel, snap_rel;
  logic [(NCH-1)*PW-1:0]   pos_diff;
  logic [TW-1:0]           count_clk, snap_ts;
  logic                    rebase, snap_valid;
  logic [NCH-1:0]          ovf;

  int n_tests = 0;
  int n_fail  = 0;

  pos_manager_n #(.NUM_CH(NCH), .POS_W(PW), .TS_W(TW)) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .clear(clear), .snap(snap),
    .pos_abs(pos_abs), .pos_rel(pos_rel), .pos_diff(pos_diff),
    .count_clk(count_clk), .rebase(rebase), .ovf(ovf),
    .snap_valid(snap_valid), .snap_ts(snap_ts), .snap_rel(snap_rel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NCH-1:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      sensor = m; tick();
      sensor = '0; tick();
    end
  endtask

  task automatic wait_rebase(input string tag);
    int n = 0;
    while (!rebase && n < 10) begin tick(); n++; end
    chk(tag, rebase, 1'b1);
  endtask

  initial begin
    int k;
    reset = 1'b1; sensor = '0; clear = '0; snap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_abs",   pos_abs, '0);
    chk("rst_rel",   pos_rel, '0);
    chk("rst_cnt",   count_clk, '0);
    chk("rst_flags", {ovf, rebase, snap_valid}, '0);
    reset = 1'b0;
    chk("cnt_start", count_clk, '0);

    // three edges on ch0
    pulse(2'b01, 3);
    repeat (3) tick();
    chk("t1_abs0", pos_abs[7:0], 8'd3);
    chk("t1_rel",  pos_rel, 16'h0003);
    chk("t1_diff", pos_diff, 8'hFD);
    chk("t1_cnt",  count_clk, 32'd9);

    clear = 2'b11; tick(); clear = '0;
    chk("clr_all", {pos_abs, pos_rel, count_clk}, '0);

    // equal rebase
    pulse(2'b11, 128);
    wait_rebase("t2_rebase");
    chk("t2_rel",  pos_rel, '0);
    chk("t2_abs",  pos_abs, 16'h8080);
    chk("t2_diff", pos_diff, 8'h00);
    tick();
    chk("t2_pulse_end", rebase, 1'b0);

    // unequal rebase keeps the difference
    pulse(2'b10, 16);
    pulse(2'b01, 128);
    wait_rebase("t2b_rebase");
    chk("t2b_rel",  pos_rel, 16'h0070);
    chk("t2b_diff", pos_diff, 8'h90);
    chk("t2b_abs",  pos_abs, 16'h9000);

    // stalled ch1: ch0 saturates
    clear = 2'b01; tick(); clear = '0;
    pulse(2'b01, 256);
    repeat (LAT + 1) tick();
    chk("t3_rel",    pos_rel, 16'h00FF);
    chk("t3_ovf",    ovf, 2'b01);
    chk("t3_rebase", rebase, 1'b1);
    clear = 2'b01; tick(); clear = '0;
    chk("t3_clr_rel", pos_rel, '0);
    chk("t3_clr_ovf", ovf, 2'b00);
    chk("t3_clr_cnt", count_clk, '0);
    chk("t3_clr_reb", rebase, 1'b0);
    chk("t3_abs",     pos_abs, 16'h9000);

    // snapshot coincident with full clear at count_clk=100
    pulse(2'b11, 3);
    pulse(2'b01, 2);
    repeat (90) tick();
    chk("t4_cnt100", count_clk, 32'd100);
    snap = 1'b1; clear = 2'b11; tick();
    snap = 1'b0; clear = '0;
    chk("t4_valid", snap_valid, 1'b1);
    chk("t4_ts",    snap_ts, 32'd100);
    chk("t4_rel",   snap_rel, 16'h0305);
    chk("t4_post",  {pos_abs, pos_rel, count_clk}, '0);
    tick();
    chk("t4_valid_end", snap_valid, 1'b0);
    chk("t4_hold",      {snap_ts, snap_rel}, {32'd100, 16'h0305});

    // back-to-back snaps
    snap = 1'b1; tick();
    chk("t4b_v1",  snap_valid, 1'b1);
    chk("t4b_ts1", snap_ts, 32'd1);
    tick(); snap = 1'b0;
    chk("t4b_v2",  snap_valid, 1'b1);
    chk("t4b_ts2", snap_ts, 32'd2);
    tick();
    chk("t4b_v3",  snap_valid, 1'b0);

    // clear[1] drops a coincident edge
    pulse(2'b01, 2);
    repeat (3) tick();
    chk("t5_pre", pos_abs[7:0], 8'd2);
    sensor = 2'b01;
    repeat (LAT - 1) tick();
    clear = 2'b10; tick(); clear = '0;
    repeat (3) tick();
    chk("t5_abs", pos_abs, '0);
    chk("t5_rel", pos_rel, 16'h0003);
    sensor = '0;
    repeat (3) tick();

    // input-to-count latency
    sensor = 2'b01;
    k = 0;
    while (k < 10) begin
      tick(); k++;
      if (pos_abs[7:0] != 8'd0) break;
    end
    chk("t6_latency", k, LAT);
    chk("t6_abs", pos_abs, 16'h0001);
    sensor = '0;

    // async reset mid-stream
    pulse(2'b11, 1);
    snap = 1'b1; tick(); snap = 1'b0;
    chk("t7_pre_valid", snap_valid, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk("t7_pos",  {pos_abs, pos_rel, pos_diff}, '0);
    chk("t7_ts",   {count_clk, snap_ts}, '0);
    chk("t7_snap", {snap_valid, snap_rel, ovf, rebase}, '0);
    tick();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
